clk_div_gen_multi: RTL and testbench
====================================

// Module: clk_div_gen_multi
// PURPOSE
//  Parametrised multi-output clock generator. Derives NUM_CLOCKS divided clocks and strobes from refclk.
//  Each channel has a runtime-programmable divide ratio and phase offset.
//  Provides a PLL-style 'locked' flag and relocks after every reconfiguration.
//  Sits between the board reference clock and downstream enable-driven logic.
// PARAMETERS
//  NUM_CLOCKS   4     number of output channels (1..16)
//  CNT_W        16    width of divide/phase counters
//  LOCK_CYCLES  1024  refclk cycles of settle time before locked asserts (>=1)
//  DEFAULT_DIV  2     divide ratio loaded into every channel at reset
//  CH_W         2     width of cfg_ch; must be >= clog2(NUM_CLOCKS)
// PORTS
//  refclk      in   1           single clock for all logic
//  rst         in   1           asynchronous, active-high reset
//  cfg_valid   in   1           config write request
//  cfg_ready   out  1           config write can be accepted
//  cfg_ch      in   CH_W        channel index of write
//  cfg_div     in   CNT_W       divide ratio D
//  cfg_phase   in   CNT_W       phase offset P, in refclk cycles
//  outclk      out  NUM_CLOCKS  divided clock per channel (registered)
//  outclk_stb  out  NUM_CLOCKS  1-cycle strobe per channel period
//  locked      out  1           all channels aligned and settled
// BEHAVIOUR
//  Clock and reset:
//   - One clock, refclk. Reset rst is asynchronous, active-high.
//   - Reset values: outclk=0, outclk_stb=0, locked=0, cfg_ready=0.
//   - Reset values: all D=DEFAULT_DIV, all P=0, FSM=SYNC.
//  FSM states SYNC -> SETTLE -> LOCKED:
//   - SYNC: lasts 1 cycle; cfg_ready=0.
//     * Every channel counter cnt is loaded with its P, clamped to 0 if P>=D.
//     * Settle counter is cleared. Next state is SETTLE.
//   - SETTLE: channel counters run; outclk and outclk_stb are forced to 0.
//     * After LOCK_CYCLES cycles in SETTLE, go to LOCKED.
//   - LOCKED: locked=1; outputs follow the channel counters.
//  Config handshake:
//   - A write is accepted when cfg_valid & cfg_ready; cfg_ready = (state != SYNC).
//   - Accepted at cycle T with cfg_ch < NUM_CLOCKS:
//     * Store D and P for that channel; next state is SYNC.
//     * locked=0 from T+1; SYNC at T+1; locked=1 at T+2+LOCK_CYCLES.
//   - Write accepted in SETTLE: restarts SYNC, so the settle time restarts in full.
//   - cfg_ch >= NUM_CLOCKS: write is accepted and discarded; no state change; locked is unaffected.
//   - After rst deasserts, the FSM runs SYNC then SETTLE, giving locked=1 LOCK_CYCLES+1 cycles after release.
//  Channel counter (per channel, D>=2):
//   - cnt counts 0..D-1, wrapping to 0.
//   - outclk is registered = (cnt < D>>1). Odd D gives (D-1)/2 cycles high.
//   - outclk_stb = 1 for one cycle whenever cnt == 0 (registered with outclk).
//   - D = 0 or 1: channel is disabled; cnt is held at 0; outclk=0 and outclk_stb=0.
//     * Such a channel still counts as locked.
//  Relative phase:
//   - All channels reload in the same SYNC cycle, so relative phase is exact after every relock.
//   - Rising edges are P cycles earlier than with P=0, modulo D.
//  Reset mid-operation: rst asserted at any point immediately forces all reset values.
//   - Stored D and P revert to their defaults.
// TESTING
//  1. Reset, LOCK_CYCLES=8, defaults:
//     -> locked=1 9 cycles after rst falls.
//     -> Every outclk toggles each cycle (D=2); outclk_stb high every 2nd cycle.
//  2. Write ch1 D=5 P=0 while locked:
//     -> locked=0 next cycle; relock after 9 more cycles.
//     -> outclk[1] is high 2 cycles, low 3; stb period 5.
//  3. Write ch0 D=8 P=0 and ch2 D=8 P=3:
//     -> After lock, outclk[2] rises 3 cycles before outclk[0].
//     -> Both have period 8; stb offset is 3.
//  4. Second write issued 4 cycles into SETTLE:
//     -> locked only 9 cycles after the second write's SYNC.
//     -> cfg_ready=0 exactly in the SYNC cycles.
//  5. Write ch3 D=1 -> outclk[3] and outclk_stb[3] stay 0, locked still asserts.
//     Write cfg_ch=5 (NUM_CLOCKS=4) -> no effect, locked stays 1.
//  6. Assert rst mid-SETTLE and mid-LOCKED:
//     -> Outputs go 0 in the same cycle.
//     -> After release, D reverts to 2 for all channels.

Source files
------------

// File: rtl/clk_div_gen_multi.sv
// Multi-output clock divider with per-channel divide ratio and phase offset.
// A shared SYNC/SETTLE/LOCKED sequencer reloads every channel counter in the
// same cycle after reset or any accepted reconfiguration, then holds outputs
// low for LOCK_CYCLES cycles before reporting lock.
module clk_div_gen_multi #(
  parameter int unsigned NUM_CLOCKS  = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_CYCLES = 1024,
  parameter int unsigned DEFAULT_DIV = 2,
  parameter int unsigned CH_W        = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [CNT_W-1:0]      cfg_div,
  input  logic [CNT_W-1:0]      cfg_phase,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] outclk_stb,
  output logic                  locked
);

  localparam int unsigned SetW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SetW-1:0] SettleLast = SetW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {StSync, StSettle, StLocked} state_e;

  state_e                state_q, state_d;
  logic [SetW-1:0]       settle_q, settle_d;
  logic [CNT_W-1:0]      div_q   [NUM_CLOCKS];
  logic [CNT_W-1:0]      div_d   [NUM_CLOCKS];
  logic [CNT_W-1:0]      phase_q [NUM_CLOCKS];
  logic [CNT_W-1:0]      phase_d [NUM_CLOCKS];
  logic [CNT_W-1:0]      cnt_q   [NUM_CLOCKS];
  logic [CNT_W-1:0]      cnt_d   [NUM_CLOCKS];
  logic [NUM_CLOCKS-1:0] outclk_q, outclk_d;
  logic [NUM_CLOCKS-1:0] stb_q, stb_d;

  logic cfg_accept;
  logic cfg_hit;

  assign cfg_ready  = (state_q != StSync);
  assign cfg_accept = cfg_valid & cfg_ready;
  // Writes to a nonexistent channel complete the handshake but change nothing.
  assign cfg_hit    = cfg_accept & ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CLOCKS));

  assign locked     = (state_q == StLocked);
  assign outclk     = outclk_q;
  assign outclk_stb = stb_q;

  // Sequencer next state: one SYNC cycle, LOCK_CYCLES of SETTLE, then LOCKED.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StSync: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StLocked;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLocked: ;
      default: state_d = StSync;
    endcase
    // Any real reconfiguration restarts the whole lock sequence.
    if (cfg_hit) begin
      state_d = StSync;
    end
  end

  // Configuration storage for the addressed channel.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      if (cfg_hit && (cfg_ch == CH_W'(i))) begin
        div_d[i]   = cfg_div;
        phase_d[i] = cfg_phase;
      end
    end
  end

  // Channel counters and their registered outputs; outputs are computed from
  // next-cycle counter/state so they line up with the counter they describe.
  always_comb begin
    for (int i = 0; i < NUM_CLOCKS; i++) begin
      cnt_d[i]    = cnt_q[i];
      outclk_d[i] = 1'b0;
      stb_d[i]    = 1'b0;
      if (state_q == StSync) begin
        cnt_d[i] = (phase_q[i] >= div_q[i]) ? '0 : phase_q[i];
      end else if (div_q[i] < CNT_W'(2)) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == div_q[i] - CNT_W'(1)) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      // A write in the same cycle forces SYNC, so div_q is stable when LOCKED.
      if ((state_d == StLocked) && (div_q[i] >= CNT_W'(2))) begin
        outclk_d[i] = (cnt_d[i] < (div_q[i] >> 1));
        stb_d[i]    = (cnt_d[i] == '0);
      end
    end
  end

  // State, configuration and channel registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q  <= StSync;
      settle_q <= '0;
      outclk_q <= '0;
      stb_q    <= '0;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= CNT_W'(DEFAULT_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      outclk_q <= outclk_d;
      stb_q    <= stb_d;
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_clk_div_gen_multi.sv
// Randomised and directed bench for clk_div_gen_multi. The reference model
// tracks only the cycle of the most recent SYNC plus each channel's D and P,
// and derives state and outputs arithmetically from elapsed cycles.
module tb_clk_div_gen_multi;

  localparam int N   = 4;
  localparam int CW  = 16;
  localparam int L   = 8;
  localparam int CHW = 3;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [CHW-1:0] cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic [CW-1:0] cfg_phase = '0;
  logic [N-1:0]  outclk;
  logic [N-1:0]  outclk_stb;
  logic          locked;

  int vectors = 0;
  int errors  = 0;
  int cyc = 0;
  int sync_cyc = 0;
  int m_div [N];
  int m_phase [N];

  clk_div_gen_multi #(
    .NUM_CLOCKS (N),
    .CNT_W      (CW),
    .LOCK_CYCLES(L),
    .DEFAULT_DIV(2),
    .CH_W       (CHW)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .outclk    (outclk),
    .outclk_stb(outclk_stb),
    .locked    (locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // 0 = SYNC, 1 = SETTLE, 2 = LOCKED
  function automatic int m_state(input int t);
    if (t == sync_cyc) return 0;
    if (t <= sync_cyc + L) return 1;
    return 2;
  endfunction

  function automatic logic [N-1:0] m_out(input int t, input bit want_stb);
    logic [N-1:0] r;
    int d, p, c;
    r = '0;
    if (m_state(t) != 2) return r;
    for (int ch = 0; ch < N; ch++) begin
      d = m_div[ch];
      if (d >= 2) begin
        p = (m_phase[ch] < d) ? m_phase[ch] : 0;
        c = (p + t - sync_cyc - 1) % d;
        r[ch] = want_stb ? (c == 0) : (c < d / 2);
      end
    end
    return r;
  endfunction

  function automatic logic [2*N+1:0] m_vec();
    return {m_state(cyc) == 2, m_state(cyc) != 0, m_out(cyc, 1'b0), m_out(cyc, 1'b1)};
  endfunction

  function automatic logic [2*N+1:0] dut_vec();
    return {locked, cfg_ready, outclk, outclk_stb};
  endfunction

  function automatic void m_reset();
    for (int ch = 0; ch < N; ch++) begin
      m_div[ch]   = 2;
      m_phase[ch] = 0;
    end
    sync_cyc = cyc;
  endfunction

  // Advance one refclk cycle and update the model with whatever was sampled.
  task automatic tick();
    bit acc;
    acc = !rst && cfg_valid && (m_state(cyc) != 0);
    @(posedge refclk);
    #1;
    cyc++;
    if (rst) begin
      sync_cyc = cyc;
    end else if (acc && (cfg_ch < N)) begin
      m_div[cfg_ch]   = cfg_div;
      m_phase[cfg_ch] = cfg_phase;
      sync_cyc = cyc;
    end
  endtask

  task automatic drive_write(input int ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(ch);
    cfg_div   = CW'(d);
    cfg_phase = CW'(p);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int first_lock;
    logic [N-1:0] prev;
    first_lock = -1;
    repeat (3) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL reset_hold: got %b expected %b", dut_vec(), m_vec());
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL reset_release: got %b expected %b", dut_vec(), m_vec());
      end
      if (locked && first_lock < 0) first_lock = i;
    end
    vectors++;
    if (first_lock !== L + 1) begin
      errors++;
      $display("FAIL reset_lock_time: got %0d expected %0d", first_lock, L + 1);
    end
    prev = outclk;
    repeat (4) begin
      tick();
      vectors++;
      if (outclk !== ~prev) begin
        errors++;
        $display("FAIL reset_div2_toggle: got %b expected %b", outclk, ~prev);
      end
      prev = outclk;
    end
  endtask

  task automatic test_div5();
    int first_lock, hi, stb;
    first_lock = -1;
    hi = 0;
    stb = 0;
    drive_write(1, 5, 0);
    vectors++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL div5_unlock: got %b expected 0", locked);
    end
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL div5_relock: got %b expected %b", dut_vec(), m_vec());
      end
      if (locked && first_lock < 0) first_lock = i;
    end
    vectors++;
    if (first_lock !== L + 1) begin
      errors++;
      $display("FAIL div5_lock_time: got %0d expected %0d", first_lock, L + 1);
    end
    repeat (10) begin
      tick();
      hi  += int'(outclk[1]);
      stb += int'(outclk_stb[1]);
    end
    vectors++;
    if (hi !== 4 || stb !== 2) begin
      errors++;
      $display("FAIL div5_duty: got high=%0d stb=%0d expected high=4 stb=2", hi, stb);
    end
  endtask

  task automatic test_phase();
    int c0, c2, off;
    c0 = -1;
    c2 = -1;
    drive_write(0, 8, 0);
    tick();
    tick();
    drive_write(2, 8, 3);
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL phase_relock: got %b expected %b", dut_vec(), m_vec());
      end
    end
    for (int i = 0; i < 16; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL phase_run: got %b expected %b", dut_vec(), m_vec());
      end
      if (outclk_stb[0] && c0 < 0) c0 = i;
      if (outclk_stb[2] && c2 < 0) c2 = i;
    end
    off = (((c0 - c2) % 8) + 8) % 8;
    vectors++;
    if (c0 < 0 || c2 < 0 || off !== 3) begin
      errors++;
      $display("FAIL phase_offset: got %0d expected 3", off);
    end
  endtask

  task automatic test_back_to_back();
    int first_lock, not_ready;
    first_lock = -1;
    not_ready = 0;
    drive_write(0, 4, 1);
    not_ready += int'(!cfg_ready);
    repeat (4) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL b2b_settle: got %b expected %b", dut_vec(), m_vec());
      end
      not_ready += int'(!cfg_ready);
    end
    drive_write(3, 6, 2);
    not_ready += int'(!cfg_ready);
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL b2b_relock: got %b expected %b", dut_vec(), m_vec());
      end
      not_ready += int'(!cfg_ready);
      if (locked && first_lock < 0) first_lock = i;
    end
    vectors++;
    if (first_lock !== L + 1) begin
      errors++;
      $display("FAIL b2b_lock_time: got %0d expected %0d", first_lock, L + 1);
    end
    vectors++;
    if (not_ready !== 2) begin
      errors++;
      $display("FAIL b2b_ready_low: got %0d expected 2", not_ready);
    end
  endtask

  task automatic test_disable();
    drive_write(3, 1, 0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      vectors++;
      if (outclk[3] !== 1'b0 || outclk_stb[3] !== 1'b0 || dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL disable_ch3: got %b expected %b", dut_vec(), m_vec());
      end
    end
    vectors++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL disable_locked: got %b expected 1", locked);
    end
    drive_write(5, 3, 1);
    for (int i = 1; i <= 10; i++) begin
      vectors++;
      if (locked !== 1'b1 || dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL bad_ch_ignored: got %b expected %b", dut_vec(), m_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] prev;
    // Mid-LOCKED: wait for some output high so the reset is visible.
    for (int i = 0; i < 10 && outclk == '0; i++) tick();
    rst = 1'b1;
    #1;
    m_reset();
    vectors++;
    if ({locked, cfg_ready, outclk, outclk_stb} !== '0) begin
      errors++;
      $display("FAIL rst_mid_locked: got %b expected 0", dut_vec());
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL rst_locked_release: got %b expected %b", dut_vec(), m_vec());
      end
    end
    // Mid-SETTLE after reprogramming channel 1.
    drive_write(1, 6, 2);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    m_reset();
    vectors++;
    if ({locked, cfg_ready, outclk, outclk_stb} !== '0) begin
      errors++;
      $display("FAIL rst_mid_settle: got %b expected 0", dut_vec());
    end
    tick();
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL rst_settle_release: got %b expected %b", dut_vec(), m_vec());
      end
    end
    prev = outclk;
    repeat (4) begin
      tick();
      vectors++;
      if (outclk !== ~prev) begin
        errors++;
        $display("FAIL rst_div_default: got %b expected %b", outclk, ~prev);
      end
      prev = outclk;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch    = CHW'($urandom_range(0, 7));
        cfg_div   = CW'($urandom_range(0, 12));
        cfg_phase = CW'($urandom_range(0, 15));
      end else begin
        cfg_valid = 1'b0;
      end
      tick();
      vectors++;
      if (dut_vec() !== m_vec()) begin
        errors++;
        $display("FAIL random: got %b expected %b at cycle %0d", dut_vec(), m_vec(), cyc);
      end
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_div5();
    test_phase();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
